// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction/address widths and the fetch response
// record passed between the fetch stage and instruction memory.
package cpu_pkg;

    localparam int INSN_W = 32;
    localparam int ADDR_W = 64;

    typedef struct packed {
        logic              fault;
        logic [INSN_W-1:0] data;
    } imem_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pop_data shows the head entry
// whenever empty is low. DEPTH must be a power of two, at least 2.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr[PW-1:0]] <= push_data;
    end

    assign pop_data = store[rd_ptr[PW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency word reads for CPU fetch,
// in-order responses through a credit-bounded FIFO, plus a preload port.
module imem_responder
    import cpu_pkg::*;
#(
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h0,
    parameter int                LATENCY     = 2,
    parameter int                OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [INSN_W-1:0]              rsp_data,
    output logic                           rsp_fault,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [INSN_W-1:0]              ld_data
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(OUTSTANDING) + 1;

    // Handshakes: a transfer happens on a clock edge where valid && ready;
    // valid never waits on ready, and payload is stable while valid && !ready.
    logic          accept;
    logic          pop;
    logic [CW-1:0] credit;

    assign req_ready = (credit < CW'(OUTSTANDING));
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // Credit = entries in the read pipeline plus entries in the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    logic [INSN_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    // The 65-bit subtract exposes the borrow, flagging addresses below BASE_ADDR.
    logic              below_base;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word_off;
    logic              dec_fault;
    imem_rsp_t         rd_rsp;

    assign {below_base, offset} = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign word_off  = offset >> 2;
    assign dec_fault = (req_addr[1:0] != 2'b00) || below_base
                       || (word_off >= ADDR_W'(DEPTH_WORDS));

    always_comb begin
        rd_rsp.fault = dec_fault;
        rd_rsp.data  = dec_fault ? '0 : mem[word_off[IW-1:0]];
    end

    logic      push_valid;
    imem_rsp_t push_rsp;

    generate
        if (LATENCY == 1) begin : g_direct
            assign push_valid = accept;
            assign push_rsp   = rd_rsp;
        end else begin : g_pipe
            logic [LATENCY-2:0] stage_v;
            imem_rsp_t          stage_d [LATENCY-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_v <= '0;
                end else begin
                    stage_v[0] <= accept;
                    for (int i = 1; i < LATENCY - 1; i++) stage_v[i] <= stage_v[i-1];
                end
            end

            always_ff @(posedge clk) begin
                stage_d[0] <= rd_rsp;
                for (int i = 1; i < LATENCY - 1; i++) stage_d[i] <= stage_d[i-1];
            end

            assign push_valid = stage_v[LATENCY-2];
            assign push_rsp   = stage_d[LATENCY-2];
        end
    endgenerate

    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    imem_rsp_t head;

    // The credit bound already guarantees room; the gate only keeps a full FIFO intact.
    assign fifo_push = push_valid && (!fifo_full || pop);

    sync_fifo #(
        .WIDTH ($bits(imem_rsp_t)),
        .DEPTH (OUTSTANDING)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_rsp),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_empty ? '0 : head.data;
    assign rsp_fault = fifo_empty ? 1'b0 : head.fault;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed fetch scenarios followed by random traffic,
// checked cycle by cycle against a queue-based transaction model.
module tb_imem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h0;
    localparam int          LAT   = 2;
    localparam int          OUTS  = 4;
    localparam int          IW    = 10;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [63:0]   req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_fault;
    logic          ld_en;
    logic [IW-1:0] ld_addr;
    logic [31:0]   ld_data;

    imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .LATENCY     (LAT),
        .OUTSTANDING (OUTS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_fault (rsp_fault),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: memory image, expected responses with the edge
    // at which each becomes visible, and the count of unconsumed requests.
    logic [31:0] ref_mem [DEPTH];
    logic [32:0] exp_q [$];
    longint      avail_q [$];
    int          credit_m;
    longint      edge_cnt;

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic logic [32:0] expect_rsp(input logic [63:0] a);
        logic [63:0] idx;
        if (a[1:0] != 2'b00 || a < BASE) return {1'b1, 32'h0};
        idx = (a - BASE) / 4;
        if (idx >= 64'(DEPTH)) return {1'b1, 32'h0};
        return {1'b0, ref_mem[int'(idx)]};
    endfunction

    // Driver: called at a falling edge. Checks the outputs, drives inputs for
    // the next rising edge, advances the model, then moves to the next falling edge.
    task automatic step(input logic rv, input logic [63:0] ra, input logic rr,
                        input logic le, input logic [IW-1:0] la, input logic [31:0] ld);
        logic exp_valid;
        logic acc;
        exp_valid = (exp_q.size() > 0) && (avail_q[0] <= edge_cnt);
        check("req_ready", 64'(req_ready), 64'(credit_m < OUTS));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("rsp_fault", 64'(rsp_fault), 64'(exp_q[0][32]));
            check("rsp_data", 64'(rsp_data), 64'(exp_q[0][31:0]));
        end
        req_valid = rv;
        req_addr  = ra;
        rsp_ready = rr;
        ld_en     = le;
        ld_addr   = la;
        ld_data   = ld;
        acc = rv && (credit_m < OUTS);
        if (acc) begin
            exp_q.push_back(expect_rsp(ra));
            avail_q.push_back(edge_cnt + LAT);
        end
        if (exp_valid && rr) begin
            void'(exp_q.pop_front());
            void'(avail_q.pop_front());
        end
        credit_m = credit_m + int'(acc) - int'(exp_valid && rr);
        if (le) ref_mem[la] = ld;
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 64'h0, rr, 1'b0, '0, 32'h0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        ld_en     = 1'b0;
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        avail_q.delete();
        credit_m = 0;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        check("reset_rsp_fault", 64'(rsp_fault), 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) idle(1, 1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [63:0] rand_addr();
        int kind;
        kind = $urandom_range(0, 9);
        if (kind == 0) return {50'($urandom_range(0, 4095)), 12'h0, 2'($urandom_range(1, 3))} >> 12;
        if (kind == 1) return 64'h1000 + 64'({$urandom_range(0, 4000), 2'b00});
        if (kind == 2) return 64'hFFFF_FFFF_FFFF_FFFC;
        return 64'({$urandom_range(0, DEPTH - 1), 2'b00});
    endfunction

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        edge_cnt  = 0;
        credit_m  = 0;
        req_addr  = '0;
        ld_addr   = '0;
        ld_data   = '0;
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        ld_en     = 1'b0;

        // Reset with no stimulus
        do_reset();
        idle(2, 1'b1);

        // Preload the whole image, then the known program words
        for (int i = 0; i < DEPTH; i++) step(1'b0, 64'h0, 1'b1, 1'b1, IW'(i), $urandom);
        step(1'b0, 64'h0, 1'b1, 1'b1, IW'(0), 32'hD503201F);
        step(1'b0, 64'h0, 1'b1, 1'b1, IW'(1), 32'h91000421);
        step(1'b0, 64'h0, 1'b1, 1'b1, IW'(2), 32'hAA0103E2);
        step(1'b0, 64'h0, 1'b1, 1'b1, IW'(3), 32'h14000000);

        // Back-to-back fetches with the consumer always ready
        for (int i = 0; i < 4; i++) step(1'b1, 64'(i * 4), 1'b1, 1'b0, '0, 32'h0);
        idle(4, 1'b1);

        // Stalled consumer: credit fills, then releases in order
        for (int i = 0; i < 7; i++) step(1'b1, 64'(16 + i * 4), 1'b0, 1'b0, '0, 32'h0);
        check("stall_queued", 64'(exp_q.size()), 64'd4);
        for (int i = 0; i < 6; i++) step(1'b1, 64'(64 + i * 4), 1'b1, 1'b0, '0, 32'h0);
        drain();

        // Misaligned, out-of-range, then a good fetch
        step(1'b1, 64'h6, 1'b1, 1'b0, '0, 32'h0);
        step(1'b1, 64'h1000, 1'b1, 1'b0, '0, 32'h0);
        step(1'b1, 64'h8, 1'b1, 1'b0, '0, 32'h0);
        drain();

        // Load and fetch of the same word on the same edge
        step(1'b1, 64'h14, 1'b1, 1'b1, IW'(5), 32'hCAFEF00D);
        idle(3, 1'b1);
        step(1'b1, 64'h14, 1'b1, 1'b0, '0, 32'h0);
        drain();

        // Reset with three queued responses and one in flight
        for (int i = 0; i < 4; i++) step(1'b1, 64'(i * 4), 1'b0, 1'b0, '0, 32'h0);
        do_reset();
        idle(4, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 64'(32 + i * 4), 1'b0, 1'b0, '0, 32'h0);
        check("post_reset_accepts", 64'(exp_q.size()), 64'd4);
        drain();

        // Random traffic with loads, stalls and one mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            logic [63:0]   a;
            logic          le;
            logic [IW-1:0] la;
            a  = rand_addr();
            le = ($urandom_range(0, 7) == 0);
            la = ($urandom_range(0, 1) == 0) ? a[IW+1:2] : IW'($urandom_range(0, DEPTH - 1));
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0, le, la, $urandom);
            if (i == 1500) do_reset();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
